usb_rx_packet_receiver: RTL and testbench

Parametrised next-generation USB full-speed packet receiver. Samples raw d_plus/d_minus and performs NRZI decode, bit unstuffing, SYNC and PID checking and EOP detection. Data bytes go into an internal show-ahead FIFO of configurable depth. Adds PID/packet status reporting and occupancy that the previous receiver lacked; sits between the USB pads and the protocol/endpoint layer.

---
 rtl/usb_rx_packet_receiver.sv | 252 +++++++++++++++++++++++++
 tb/tb_usb_rx_packet_receiver.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_rx_packet_receiver.sv
// Full-speed USB receive path: input sync, bit timing, NRZI decode, unstuffing, SYNC/PID/EOP
// checking, and a show-ahead byte FIFO with packet status outputs.
//  state | meaning
//  IDLE  | line idle (J), waiting for the first D+ falling edge
//  SYNC  | collecting SYNC byte, must decode to 0x80
//  PID   | collecting PID byte, upper nibble must be complement of lower
//  DATA  | collecting data bytes into the FIFO
//  EOP   | first SE0 seen on a byte boundary, expecting second SE0 then J
//  ABORT | error latched, waiting for SE0 then J
module usb_rx_packet_receiver #(
    parameter int CLKS_PER_BIT = 8,
    parameter int SAMPLE_PT    = 3,
    parameter int FIFO_DEPTH   = 8,
    localparam int CW          = $clog2(FIFO_DEPTH) + 1
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          d_plus,
    input  logic          d_minus,
    input  logic          r_enable,
    output logic [7:0]    r_data,
    output logic          empty,
    output logic          full,
    output logic [CW-1:0] count,
    output logic          rcving,
    output logic          r_error,
    output logic [3:0]    pid,
    output logic          pid_valid,
    output logic          packet_done,
    output logic [7:0]    byte_count
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int AW = CW - 1;

    typedef enum logic [2:0] {IDLE, SYNC, PID, DATA, EOP, ABORT} state_t;

    logic          dp_meta_q, dp_sync_q, dp_prev_q, dm_meta_q, dm_sync_q;
    logic [TW-1:0] timer_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            dp_meta_q <= 1'b1;
            dp_sync_q <= 1'b1;
            dp_prev_q <= 1'b1;
            dm_meta_q <= 1'b0;
            dm_sync_q <= 1'b0;
            timer_q   <= '0;
        end else begin
            dp_meta_q <= d_plus;
            dp_sync_q <= dp_meta_q;
            dp_prev_q <= dp_sync_q;
            dm_meta_q <= d_minus;
            dm_sync_q <= dm_meta_q;
            // any D+ transition re-centres the bit timer on the incoming edge
            if (dp_sync_q != dp_prev_q || timer_q == TW'(CLKS_PER_BIT - 1))
                timer_q <= '0;
            else
                timer_q <= timer_q + 1'b1;
        end
    end

    state_t       state_q, state_d;
    logic         prev_smp_q, prev_smp_d;
    logic [2:0]   ones_q, ones_d, bit_cnt_q, bit_cnt_d;
    logic [7:0]   shift_q, shift_d, push_data_q, push_data_d, byte_count_q, byte_count_d;
    logic         push_q, push_d, rcving_q, rcving_d, r_error_q, r_error_d;
    logic [3:0]   pid_q, pid_d;
    logic         pid_valid_q, pid_valid_d, packet_done_q, packet_done_d;
    logic         eop_se0_q, eop_se0_d, abort_se0_q, abort_se0_d;
    logic         sample, se0, line_j, nrzi_bit, go_abort, drop;
    logic [7:0]   new_byte;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          push_ok, pop_ok;

    assign sample   = (timer_q == TW'(SAMPLE_PT));
    assign se0      = sample && !dp_sync_q && !dm_sync_q;
    assign line_j   = dp_sync_q && !dm_sync_q;
    assign nrzi_bit = (dp_sync_q == prev_smp_q);
    assign new_byte = {nrzi_bit, shift_q[7:1]};

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign push_ok = push_q && (!full || r_enable);
    assign pop_ok  = r_enable && (!empty || push_q);
    assign drop    = push_q && full && !r_enable;

    always_comb begin
        state_d       = state_q;
        prev_smp_d    = prev_smp_q;
        ones_d        = ones_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        push_d        = 1'b0;
        push_data_d   = push_data_q;
        rcving_d      = rcving_q;
        r_error_d     = r_error_q;
        pid_d         = pid_q;
        pid_valid_d   = 1'b0;
        packet_done_d = 1'b0;
        byte_count_d  = byte_count_q;
        eop_se0_d     = eop_se0_q;
        abort_se0_d   = abort_se0_q;
        go_abort      = 1'b0;
        if (push_q && !drop && byte_count_q != 8'hFF)
            byte_count_d = byte_count_q + 1'b1;
        case (state_q)
            IDLE: begin
                prev_smp_d = 1'b1;
                ones_d     = '0;
                bit_cnt_d  = '0;
                if (dp_prev_q && !dp_sync_q) begin
                    state_d      = SYNC;
                    rcving_d     = 1'b1;
                    byte_count_d = '0;
                    r_error_d    = 1'b0;
                end
            end
            SYNC, PID, DATA: if (sample) begin
                if (se0) begin
                    if (state_q == DATA && bit_cnt_q == '0) begin
                        state_d   = EOP;
                        eop_se0_d = 1'b0;
                    end else begin
                        go_abort = 1'b1;
                    end
                end else begin
                    prev_smp_d = dp_sync_q;
                    if (ones_q == 3'd6) begin
                        // stuffed bit: discarded, must have been a 0
                        ones_d = '0;
                        if (nrzi_bit) go_abort = 1'b1;
                    end else begin
                        ones_d    = nrzi_bit ? ones_q + 1'b1 : '0;
                        shift_d   = new_byte;
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) begin
                            if (state_q == SYNC) begin
                                if (new_byte == 8'h80) state_d = PID;
                                else                   go_abort = 1'b1;
                            end else if (state_q == PID) begin
                                if (new_byte[7:4] == ~new_byte[3:0]) begin
                                    pid_d       = new_byte[3:0];
                                    pid_valid_d = 1'b1;
                                    state_d     = DATA;
                                end else begin
                                    go_abort = 1'b1;
                                end
                            end else begin
                                push_d      = 1'b1;
                                push_data_d = new_byte;
                            end
                        end
                    end
                end
            end
            EOP: if (sample) begin
                if (!eop_se0_q) begin
                    if (se0) eop_se0_d = 1'b1;
                    else     go_abort  = 1'b1;
                end else if (line_j) begin
                    packet_done_d = 1'b1;
                    rcving_d      = 1'b0;
                    state_d       = IDLE;
                end else begin
                    go_abort = 1'b1;
                end
            end
            ABORT: if (sample) begin
                if (se0) begin
                    abort_se0_d = 1'b1;
                end else if (line_j && abort_se0_q) begin
                    rcving_d = 1'b0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (drop) go_abort = 1'b1;
        if (go_abort) begin
            state_d       = ABORT;
            r_error_d     = 1'b1;
            abort_se0_d   = se0;
            pid_valid_d   = 1'b0;
            packet_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q       <= IDLE;
            prev_smp_q    <= 1'b1;
            ones_q        <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            push_q        <= 1'b0;
            push_data_q   <= '0;
            rcving_q      <= 1'b0;
            r_error_q     <= 1'b0;
            pid_q         <= '0;
            pid_valid_q   <= 1'b0;
            packet_done_q <= 1'b0;
            byte_count_q  <= '0;
            eop_se0_q     <= 1'b0;
            abort_se0_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            prev_smp_q    <= prev_smp_d;
            ones_q        <= ones_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            push_q        <= push_d;
            push_data_q   <= push_data_d;
            rcving_q      <= rcving_d;
            r_error_q     <= r_error_d;
            pid_q         <= pid_d;
            pid_valid_q   <= pid_valid_d;
            packet_done_q <= packet_done_d;
            byte_count_q  <= byte_count_d;
            eop_se0_q     <= eop_se0_d;
            abort_se0_q   <= abort_se0_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q] <= push_data_q;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_ok && !pop_ok)      count_q <= count_q + 1'b1;
            else if (pop_ok && !push_ok) count_q <= count_q - 1'b1;
        end
    end

    assign r_data      = empty ? 8'h00 : mem[rd_ptr_q];
    assign count       = count_q;
    assign rcving      = rcving_q;
    assign r_error     = r_error_q;
    assign pid         = pid_q;
    assign pid_valid   = pid_valid_q;
    assign packet_done = packet_done_q;
    assign byte_count  = byte_count_q;
endmodule

// File: tb/tb_usb_rx_packet_receiver.sv
// Bench for usb_rx_packet_receiver: a bit-level USB encoder drives a table of packets into an
// 8-deep instance and hand-written sequences into a 4-deep instance; FIFO bytes checked via a queue.
module tb_usb_rx_packet_receiver;
    localparam int CPB = 8;

    logic clk = 1'b0, n_rst = 1'b0, dp = 1'b1, dm = 1'b0, sel4 = 1'b0, ren = 1'b0;

    logic [7:0] r_data8, bc8, r_data4, bc4;
    logic [3:0] count8, pid8, pid4;
    logic [2:0] count4;
    logic empty8, full8, rcv8, err8, pv8, pd8;
    logic empty4, full4, rcv4, err4, pv4, pd4;

    logic [7:0] s_rdata, s_bc;
    logic [3:0] s_count, s_pid;
    logic s_empty, s_full, s_rcv, s_err, s_pv, s_pd;

    always #5 clk = ~clk;

    usb_rx_packet_receiver dut8 (
        .clk(clk), .n_rst(n_rst), .d_plus(sel4 ? 1'b1 : dp), .d_minus(sel4 ? 1'b0 : dm),
        .r_enable(ren & ~sel4), .r_data(r_data8), .empty(empty8), .full(full8), .count(count8),
        .rcving(rcv8), .r_error(err8), .pid(pid8), .pid_valid(pv8), .packet_done(pd8),
        .byte_count(bc8)
    );

    usb_rx_packet_receiver #(.FIFO_DEPTH(4)) dut4 (
        .clk(clk), .n_rst(n_rst), .d_plus(sel4 ? dp : 1'b1), .d_minus(sel4 ? dm : 1'b0),
        .r_enable(ren & sel4), .r_data(r_data4), .empty(empty4), .full(full4), .count(count4),
        .rcving(rcv4), .r_error(err4), .pid(pid4), .pid_valid(pv4), .packet_done(pd4),
        .byte_count(bc4)
    );

    always_comb begin
        s_rdata = sel4 ? r_data4 : r_data8;
        s_bc    = sel4 ? bc4 : bc8;
        s_count = sel4 ? {1'b0, count4} : count8;
        s_pid   = sel4 ? pid4 : pid8;
        s_empty = sel4 ? empty4 : empty8;
        s_full  = sel4 ? full4 : full8;
        s_rcv   = sel4 ? rcv4 : rcv8;
        s_err   = sel4 ? err4 : err8;
        s_pv    = sel4 ? pv4 : pv8;
        s_pd    = sel4 ? pd4 : pd8;
    end

    int pv_n = 0, pd_n = 0;
    always @(negedge clk) begin
        if (s_pv) pv_n++;
        if (s_pd) pd_n++;
    end

    int checks = 0, failures = 0;
    logic [7:0] exp_q[$];
    logic [3:0] last_pid = 4'h0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- line encoder ----------------
    logic lvl = 1'b1;
    int   ones = 0;
    bit   bad_stuff = 1'b0;

    task automatic drive_lvl(input logic p, input logic m, input bit pop);
        dp = p;
        dm = m;
        if (pop) begin
            // r_enable lands in the cycle the receiver pushes the byte ending with this bit
            repeat (CPB - 1) @(posedge clk);
            #1 ren = 1'b1;
            @(posedge clk);
            #1 ren = 1'b0;
        end else begin
            repeat (CPB) @(posedge clk);
            #1;
        end
    endtask

    task automatic tx_bit(input bit b, input bit pop);
        if (!b) lvl = ~lvl;
        drive_lvl(lvl, ~lvl, pop);
        ones = b ? ones + 1 : 0;
        if (ones == 6) begin
            if (!bad_stuff) lvl = ~lvl;
            bad_stuff = 1'b0;
            drive_lvl(lvl, ~lvl, 1'b0);
            ones = 0;
        end
    endtask

    task automatic tx_bits(input logic [7:0] b, input int n, input bit pop_last);
        for (int i = 0; i < n; i++) tx_bit(b[i], pop_last && i == n - 1);
    endtask

    task automatic send_start(input logic [7:0] p);
        lvl  = 1'b1;
        ones = 0;
        tx_bits(8'h80, 8, 1'b0);
        tx_bits(p, 8, 1'b0);
    endtask

    task automatic send_eop();
        drive_lvl(1'b0, 1'b0, 1'b0);
        drive_lvl(1'b0, 1'b0, 1'b0);
        drive_lvl(1'b1, 1'b0, 1'b0);
        lvl = 1'b1;
        drive_lvl(1'b1, 1'b0, 1'b0);
        drive_lvl(1'b1, 1'b0, 1'b0);
    endtask

    task automatic drain(input string tag);
        logic [7:0] e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            @(negedge clk);
            check({tag, " r_data"}, {24'h0, s_rdata}, {24'h0, e});
            @(posedge clk);
            #1 ren = 1'b1;
            @(posedge clk);
            #1 ren = 1'b0;
        end
        @(negedge clk);
        check({tag, " empty after reads"}, {31'h0, s_empty}, 32'h1);
        check({tag, " r_data when empty"}, {24'h0, s_rdata}, 32'h0);
    endtask

    // ---------------- packet table ----------------
    typedef struct {
        string       name;
        logic [7:0]  pid;
        int          n;
        logic [4:0][7:0] d;
        bit          bad;
        int          trunc;
        bit          pv;
        bit          done;
        bit          err;
        int          bc;
        int          cnt;
    } vec_t;

    vec_t vecs[7];

    task automatic set_vec(input int i, input string name, input logic [7:0] p, input int n,
                           input logic [39:0] d, input bit bad, input int trunc, input bit pv,
                           input bit done, input bit err, input int bc, input int cnt);
        vecs[i].name = name;  vecs[i].pid = p;     vecs[i].n = n;
        vecs[i].d = d;        vecs[i].bad = bad;   vecs[i].trunc = trunc;
        vecs[i].pv = pv;      vecs[i].done = done; vecs[i].err = err;
        vecs[i].bc = bc;      vecs[i].cnt = cnt;
    endtask

    task automatic run_vec(input int k);
        int pv0, pd0;
        pv0 = pv_n;
        pd0 = pd_n;
        send_start(vecs[k].pid);
        bad_stuff = vecs[k].bad;
        check({vecs[k].name, " rcving mid"}, {31'h0, s_rcv}, 32'h1);
        for (int i = 0; i < vecs[k].n; i++) begin
            if (i < vecs[k].cnt) exp_q.push_back(vecs[k].d[i]);
            tx_bits(vecs[k].d[i], 8, 1'b0);
        end
        if (vecs[k].trunc > 0) tx_bits(8'h99, vecs[k].trunc, 1'b0);
        bad_stuff = 1'b0;
        send_eop();
        @(negedge clk);
        check({vecs[k].name, " pid_valid pulses"}, pv_n - pv0, {31'h0, vecs[k].pv});
        check({vecs[k].name, " packet_done pulses"}, pd_n - pd0, {31'h0, vecs[k].done});
        check({vecs[k].name, " r_error"}, {31'h0, s_err}, {31'h0, vecs[k].err});
        check({vecs[k].name, " rcving end"}, {31'h0, s_rcv}, 32'h0);
        check({vecs[k].name, " byte_count"}, {24'h0, s_bc}, vecs[k].bc);
        check({vecs[k].name, " count"}, {28'h0, s_count}, vecs[k].cnt);
        if (vecs[k].pv) last_pid = vecs[k].pid[3:0];
        check({vecs[k].name, " pid"}, {28'h0, s_pid}, {28'h0, last_pid});
        drain(vecs[k].name);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int pv0, pd0;
        //        name          pid    n  data (byte0 lowest)  bad trunc pv done err bc cnt
        set_vec(0, "clean",     8'hC3, 2, 40'h00_0000_3CA5, 0, 0, 1, 1, 0, 2, 2);
        set_vec(1, "stuff_ok",  8'h4B, 2, 40'h00_0000_7FFF, 0, 0, 1, 1, 0, 2, 2);
        set_vec(2, "stuff_bad", 8'h4B, 2, 40'h00_0000_7FFF, 1, 0, 1, 0, 1, 0, 0);
        set_vec(3, "pid_bad",   8'hC4, 1, 40'h00_0000_0011, 0, 0, 0, 0, 1, 0, 0);
        set_vec(4, "trunc",     8'hC3, 1, 40'h00_0000_005A, 0, 4, 1, 0, 1, 1, 1);
        set_vec(5, "handshake", 8'hD2, 0, 40'h00_0000_0000, 0, 0, 1, 1, 0, 0, 0);
        set_vec(6, "three",     8'hC3, 3, 40'h00_0080_FF00, 0, 0, 1, 1, 0, 3, 3);

        repeat (4) @(posedge clk);
        @(negedge clk);
        check("reset empty", {31'h0, empty8}, 32'h1);
        check("reset full", {31'h0, full8}, 32'h0);
        check("reset count", {28'h0, count8}, 32'h0);
        check("reset r_data", {24'h0, r_data8}, 32'h0);
        check("reset rcving", {31'h0, rcv8}, 32'h0);
        check("reset r_error", {31'h0, err8}, 32'h0);
        check("reset pid", {28'h0, pid8}, 32'h0);
        check("reset pulses", {30'h0, pv8, pd8}, 32'h0);
        check("reset byte_count", {24'h0, bc8}, 32'h0);
        check("reset dut4 count", {29'h0, count4}, 32'h0);
        @(posedge clk);
        #1 n_rst = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        #1;

        for (int k = 0; k < 7; k++) run_vec(k);

        // 4-deep FIFO: fifth byte overflows
        sel4 = 1'b1;
        repeat (2 * CPB) @(posedge clk);
        #1;
        pd0 = pd_n;
        send_start(8'hC3);
        for (int i = 1; i <= 5; i++) begin
            if (i <= 4) exp_q.push_back(8'(i));
            tx_bits(8'(i), 8, 1'b0);
        end
        send_eop();
        @(negedge clk);
        check("ovf full", {31'h0, s_full}, 32'h1);
        check("ovf count", {28'h0, s_count}, 32'h4);
        check("ovf r_error", {31'h0, s_err}, 32'h1);
        check("ovf packet_done", pd_n - pd0, 32'h0);
        check("ovf byte_count", {24'h0, s_bc}, 32'h4);
        drain("ovf");

        // 4-deep FIFO: fifth byte arrives with a same-cycle read
        pd0 = pd_n;
        send_start(8'hC3);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) exp_q.push_back(8'h11 + 8'(i));
            tx_bits(8'h11 + 8'(i), 8, 1'b0);
        end
        @(negedge clk);
        check("pushpop full before", {31'h0, s_full}, 32'h1);
        exp_q.push_back(8'h15);
        tx_bits(8'h15, 8, 1'b1);
        @(negedge clk);
        check("pushpop count at push", {28'h0, s_count}, 32'h4);
        send_eop();
        @(negedge clk);
        check("pushpop count", {28'h0, s_count}, 32'h4);
        check("pushpop r_error", {31'h0, s_err}, 32'h0);
        check("pushpop packet_done", pd_n - pd0, 32'h1);
        check("pushpop byte_count", {24'h0, s_bc}, 32'h5);
        drain("pushpop");

        // reset in the middle of the third byte
        sel4 = 1'b0;
        repeat (2 * CPB) @(posedge clk);
        #1;
        send_start(8'hC3);
        tx_bits(8'h11, 8, 1'b0);
        tx_bits(8'h22, 8, 1'b0);
        tx_bits(8'h33, 3, 1'b0);
        @(negedge clk);
        check("midrst count before", {28'h0, count8}, 32'h2);
        check("midrst rcving before", {31'h0, rcv8}, 32'h1);
        #2 n_rst = 1'b0;
        #1;
        check("midrst empty", {31'h0, empty8}, 32'h1);
        check("midrst count", {28'h0, count8}, 32'h0);
        check("midrst rcving", {31'h0, rcv8}, 32'h0);
        check("midrst pid", {28'h0, pid8}, 32'h0);
        check("midrst byte_count", {24'h0, bc8}, 32'h0);
        check("midrst r_data", {24'h0, r_data8}, 32'h0);
        dp = 1'b1;
        dm = 1'b0;
        lvl = 1'b1;
        exp_q.delete();
        last_pid = 4'h0;
        repeat (3) @(posedge clk);
        #1 n_rst = 1'b1;
        repeat (3 * CPB) @(posedge clk);
        #1;
        run_vec(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
